// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, fetch FSM states and the NOOP encoding.
package cpu_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 16;

    // ISSUE: memory read of PC in flight, CAPTURE: IM_DATA valid for PC,
    // READY: prefetch buffer holds the word at PC.
    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2
    } fetch_state_t;

    // Instruction register contents after reset.
    localparam logic [DATA_W_DEFAULT-1:0] NOOP = 16'h0000;

endpackage

// File: rtl/pc_register.sv
// Program counter with clear / load / relative load / increment priority mux
// and a sticky flag recording that an increment rolled over past all-ones.
module pc_register #(
    parameter int ADDR_W = cpu_pkg::ADDR_W_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              clear,
    input  logic              load,
    input  logic              load_rel,
    input  logic              incr,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_wrap
);

    // PC update: Reset > clear > load > increment, one change per cycle.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order or block ordering.
    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            pc      <= '0;
            pc_wrap <= 1'b0;
        end else if (load) begin
            // Offset and PC have the same width, so a plain modulo add is the
            // sign-extended relative jump; a load never touches pc_wrap.
            pc <= load_rel ? pc + target : target;
        end else if (incr) begin
            pc <= pc + ADDR_W'(1);
            if (&pc) begin
                pc_wrap <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction
// memory, keeps a one-word prefetch buffer and loads IR for the control unit.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              PC_CLR,
    input  logic              PR_ID,
    input  logic              PC_IC,
    input  logic              PC_LD,
    input  logic              PC_LD_REL,
    input  logic [ADDR_W-1:0] PC_TARGET,
    output logic              IM_EN,
    output logic [ADDR_W-1:0] IM_ADDR,
    input  logic [DATA_W-1:0] IM_DATA,
    output logic [DATA_W-1:0] IR,
    output logic              IR_VALID,
    output logic [ADDR_W-1:0] PC,
    output logic              FETCH_BUSY,
    output logic              PC_WRAP
);

    fetch_state_t      state;
    logic [DATA_W-1:0] pf;
    logic              pending;
    logic              pc_change;

    // Any accepted PC command restarts the refill from the new address.
    assign pc_change = PC_CLR | PC_LD | PC_IC;

    pc_register #(.ADDR_W(ADDR_W)) u_pc (
        .Clock    (Clock),
        .Reset    (Reset),
        .clear    (PC_CLR),
        .load     (PC_LD),
        .load_rel (PC_LD_REL),
        .incr     (PC_IC),
        .target   (PC_TARGET),
        .pc       (PC),
        .pc_wrap  (PC_WRAP)
    );

    assign IM_EN   = (state == ISSUE);
    assign IM_ADDR = PC;

    // Prefetch buffer: captures the returning word when a refill completes.
    // NOTE: pf carries no reset; whether it holds a usable word is tracked
    // entirely by state, so resetting the data would only add logic.
    always_ff @(posedge Clock) begin
        if (state == CAPTURE && !pc_change) begin
            pf <= IM_DATA;
        end
    end

    // Fetch FSM plus IR / IR_VALID / pending / FETCH_BUSY bookkeeping.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ISSUE;
            IR         <= DATA_W'(NOOP);
            IR_VALID   <= 1'b0;
            pending    <= 1'b0;
            FETCH_BUSY <= 1'b1;
        end else begin
            // Request from the control unit: serve from PF or defer to refill.
            if (PR_ID) begin
                if (state == READY) begin
                    IR       <= pf;
                    IR_VALID <= 1'b1;
                end else begin
                    pending  <= 1'b1;
                    IR_VALID <= 1'b0;
                end
            end

            if (pc_change) begin
                // Drops PF and any in-flight read; pending survives.
                state      <= ISSUE;
                FETCH_BUSY <= 1'b1;
            end else begin
                case (state)
                    ISSUE: begin
                        state <= CAPTURE;
                    end
                    CAPTURE: begin
                        state      <= READY;
                        FETCH_BUSY <= 1'b0;
                        // A request arriving on this very edge is served too,
                        // otherwise it would sit in READY with nobody to serve it.
                        if (pending || PR_ID) begin
                            IR       <= IM_DATA;
                            IR_VALID <= 1'b1;
                            pending  <= 1'b0;
                        end
                    end
                    READY: begin
                        state <= READY;
                    end
                    default: begin
                        state <= ISSUE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural synchronous memory, a
// queue of expected IR words pushed on PR_ID and popped when IR is loaded.
module tb_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        PC_CLR = 1'b0;
    logic        PR_ID = 1'b0;
    logic        PC_IC = 1'b0;
    logic        PC_LD = 1'b0;
    logic        PC_LD_REL = 1'b0;
    logic [7:0]  PC_TARGET = 8'h00;
    logic        IM_EN;
    logic [7:0]  IM_ADDR;
    logic [15:0] IM_DATA = 16'h0000;
    logic [15:0] IR;
    logic        IR_VALID;
    logic [7:0]  PC;
    logic        FETCH_BUSY;
    logic        PC_WRAP;

    logic [15:0] mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] exp_ir = 16'h0000;
    int          n_checks = 0;
    int          n_fail = 0;

    fetch_unit dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .PC_CLR     (PC_CLR),
        .PR_ID      (PR_ID),
        .PC_IC      (PC_IC),
        .PC_LD      (PC_LD),
        .PC_LD_REL  (PC_LD_REL),
        .PC_TARGET  (PC_TARGET),
        .IM_EN      (IM_EN),
        .IM_ADDR    (IM_ADDR),
        .IM_DATA    (IM_DATA),
        .IR         (IR),
        .IR_VALID   (IR_VALID),
        .PC         (PC),
        .FETCH_BUSY (FETCH_BUSY),
        .PC_WRAP    (PC_WRAP)
    );

    always #5 Clock = ~Clock;

    // Synchronous instruction memory: data valid the cycle after IM_EN.
    always @(posedge Clock) begin
        if (IM_EN) IM_DATA <= mem[IM_ADDR];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All driving and sampling happens at the falling edge.
    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic load_pc(input logic [7:0] a);
        PC_LD = 1'b1; PC_LD_REL = 1'b0; PC_TARGET = a;
        tick();
        PC_LD = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(); tick();
        n_checks++; if (PC !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h, expected 00", PC); end
        n_checks++; if (IR !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h, expected 0000", IR); end
        n_checks++; if (IR_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %b, expected 0", IR_VALID); end
        n_checks++; if (PC_WRAP !== 1'b0) begin n_fail++; $display("FAIL reset_pc_wrap: got %b, expected 0", PC_WRAP); end
        n_checks++; if (FETCH_BUSY !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b, expected 1", FETCH_BUSY); end
        Reset = 1'b0;
        n_checks++; if (IM_EN !== 1'b1 || IM_ADDR !== 8'h00) begin n_fail++; $display("FAIL issue_im: got en=%b addr=%h, expected en=1 addr=00", IM_EN, IM_ADDR); end
        tick();
        n_checks++; if (IM_EN !== 1'b0 || FETCH_BUSY !== 1'b1) begin n_fail++; $display("FAIL capture_state: got en=%b busy=%b, expected en=0 busy=1", IM_EN, FETCH_BUSY); end
        tick();
        n_checks++; if (FETCH_BUSY !== 1'b0) begin n_fail++; $display("FAIL ready_after_reset: got busy=%b, expected 0", FETCH_BUSY); end
        PR_ID = 1'b1; exp_q.push_back(mem[0]);
        tick();
        PR_ID = 1'b0;
        n_checks++; if (IR_VALID !== 1'b1) begin n_fail++; $display("FAIL ready_ir_valid: got %b, expected 1", IR_VALID); end
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL ready_ir: scoreboard empty"); end
        else begin exp_ir = exp_q.pop_front(); if (IR !== exp_ir) begin n_fail++; $display("FAIL ready_ir: got %h, expected %h", IR, exp_ir); end end
    endtask

    task automatic test_pending_at_issue();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        PR_ID = 1'b1; exp_q.push_back(mem[0]);
        tick();
        PR_ID = 1'b0;
        n_checks++; if (IR_VALID !== 1'b0) begin n_fail++; $display("FAIL pend_valid_low: got %b, expected 0", IR_VALID); end
        tick();
        n_checks++; if (IR_VALID !== 1'b1 || FETCH_BUSY !== 1'b0) begin n_fail++; $display("FAIL pend_served: got valid=%b busy=%b, expected 1/0", IR_VALID, FETCH_BUSY); end
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL pend_ir: scoreboard empty"); end
        else begin exp_ir = exp_q.pop_front(); if (IR !== exp_ir) begin n_fail++; $display("FAIL pend_ir: got %h, expected %h", IR, exp_ir); end end
    endtask

    task automatic test_pr_id_with_inc();
        load_pc(8'h10);
        PR_ID = 1'b1; PC_IC = 1'b1; exp_q.push_back(mem[8'h10]);
        tick();
        PR_ID = 1'b0; PC_IC = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL inc_ir_old_pc: scoreboard empty"); end
        else begin exp_ir = exp_q.pop_front(); if (IR !== exp_ir) begin n_fail++; $display("FAIL inc_ir_old_pc: got %h, expected %h", IR, exp_ir); end end
        n_checks++; if (PC !== 8'h11 || FETCH_BUSY !== 1'b1) begin n_fail++; $display("FAIL inc_pc: got pc=%h busy=%b, expected 11/1", PC, FETCH_BUSY); end
        tick();
        n_checks++; if (FETCH_BUSY !== 1'b1) begin n_fail++; $display("FAIL inc_busy2: got %b, expected 1", FETCH_BUSY); end
        tick();
        n_checks++; if (FETCH_BUSY !== 1'b0) begin n_fail++; $display("FAIL inc_ready: got %b, expected 0", FETCH_BUSY); end
        PR_ID = 1'b1; exp_q.push_back(mem[8'h11]);
        tick();
        PR_ID = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL inc_ir_new_pc: scoreboard empty"); end
        else begin exp_ir = exp_q.pop_front(); if (IR !== exp_ir) begin n_fail++; $display("FAIL inc_ir_new_pc: got %h, expected %h", IR, exp_ir); end end
    endtask

    task automatic test_pc_load();
        load_pc(8'h10);
        PC_LD = 1'b1; PC_LD_REL = 1'b1; PC_TARGET = 8'hFC;
        tick();
        n_checks++; if (PC !== 8'h0C) begin n_fail++; $display("FAIL ld_rel: got %h, expected 0C", PC); end
        PC_LD_REL = 1'b0; PC_TARGET = 8'h40;
        tick();
        n_checks++; if (PC !== 8'h40) begin n_fail++; $display("FAIL ld_abs: got %h, expected 40", PC); end
        PC_LD = 1'b0; PC_LD_REL = 1'b1; PC_TARGET = 8'h33;
        tick();
        n_checks++; if (PC !== 8'h40) begin n_fail++; $display("FAIL rel_without_ld: got %h, expected 40", PC); end
        PC_LD_REL = 1'b0;
        PC_CLR = 1'b1; PC_LD = 1'b1; PC_TARGET = 8'h55;
        tick();
        PC_CLR = 1'b0; PC_LD = 1'b0;
        n_checks++; if (PC !== 8'h00) begin n_fail++; $display("FAIL clr_over_ld: got %h, expected 00", PC); end
        n_checks++; if (IR !== exp_ir) begin n_fail++; $display("FAIL clr_keeps_ir: got %h, expected %h", IR, exp_ir); end
    endtask

    task automatic test_wrap();
        load_pc(8'hFF);
        n_checks++; if (PC_WRAP !== 1'b0) begin n_fail++; $display("FAIL wrap_initial: got %b, expected 0", PC_WRAP); end
        PC_IC = 1'b1;
        tick();
        n_checks++; if (PC !== 8'h00 || PC_WRAP !== 1'b1) begin n_fail++; $display("FAIL wrap_set: got pc=%h wrap=%b, expected 00/1", PC, PC_WRAP); end
        tick();
        PC_IC = 1'b0;
        n_checks++; if (PC !== 8'h01 || PC_WRAP !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky: got pc=%h wrap=%b, expected 01/1", PC, PC_WRAP); end
        PC_CLR = 1'b1;
        tick();
        PC_CLR = 1'b0;
        n_checks++; if (PC_WRAP !== 1'b0) begin n_fail++; $display("FAIL wrap_clear: got %b, expected 0", PC_WRAP); end
        load_pc(8'hF0);
        PC_LD = 1'b1; PC_LD_REL = 1'b1; PC_TARGET = 8'h20;
        tick();
        PC_LD = 1'b0; PC_LD_REL = 1'b0;
        n_checks++; if (PC !== 8'h10 || PC_WRAP !== 1'b0) begin n_fail++; $display("FAIL ld_wrap_no_flag: got pc=%h wrap=%b, expected 10/0", PC, PC_WRAP); end
    endtask

    task automatic test_stale_capture();
        PC_LD = 1'b1; PC_TARGET = 8'h30;
        tick();
        PC_LD = 1'b0;
        PR_ID = 1'b1; exp_q.push_back(mem[8'h20]);
        tick();
        PR_ID = 1'b0;
        n_checks++; if (IR_VALID !== 1'b0) begin n_fail++; $display("FAIL stale_pending: got valid=%b, expected 0", IR_VALID); end
        PC_LD = 1'b1; PC_TARGET = 8'h20;
        tick();
        PC_LD = 1'b0;
        n_checks++; if (IR_VALID !== 1'b0 || PC !== 8'h20) begin n_fail++; $display("FAIL stale_discard: got valid=%b pc=%h, expected 0/20", IR_VALID, PC); end
        tick();
        n_checks++; if (IR_VALID !== 1'b0) begin n_fail++; $display("FAIL stale_wait: got valid=%b, expected 0", IR_VALID); end
        tick();
        n_checks++; if (IR_VALID !== 1'b1) begin n_fail++; $display("FAIL stale_served: got valid=%b, expected 1", IR_VALID); end
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stale_ir: scoreboard empty"); end
        else begin exp_ir = exp_q.pop_front(); if (IR !== exp_ir) begin n_fail++; $display("FAIL stale_ir: got %h, expected %h", IR, exp_ir); end end
    endtask

    task automatic test_back_to_back();
        load_pc(8'h80);
        for (int i = 0; i < 4; i++) begin
            PR_ID = 1'b1; PC_IC = 1'b1; exp_q.push_back(mem[8'h80 + i]);
            tick();
            PR_ID = 1'b0; PC_IC = 1'b0;
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_ir[%0d]: scoreboard empty", i); end
            else begin exp_ir = exp_q.pop_front(); if (IR !== exp_ir) begin n_fail++; $display("FAIL b2b_ir[%0d]: got %h, expected %h", i, IR, exp_ir); end end
            n_checks++; if (PC !== 8'(8'h81 + i)) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h, expected %h", i, PC, 8'(8'h81 + i)); end
            tick(); tick();
        end
        for (int i = 0; i < 2; i++) begin
            PR_ID = 1'b1; exp_q.push_back(mem[8'h84]);
            tick();
            n_checks++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_ready[%0d]: scoreboard empty", i); end
            else begin exp_ir = exp_q.pop_front(); if (IR !== exp_ir || IR_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %h valid=%b, expected %h valid=1", i, IR, IR_VALID, exp_ir); end end
        end
        PR_ID = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'(i) ^ 8'h5A, ~8'(i)};
        end
        mem[0] = 16'h1234;

        @(negedge Clock);
        test_reset();
        test_pending_at_issue();
        test_pr_id_with_inc();
        test_pc_load();
        test_wrap();
        test_stale_capture();
        test_back_to_back();

        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size()); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
